// File: rtl/sram_ext_controller_if.sv
// Request/response bundle between the SoC memory mux (master) and the
// external-SRAM backend (slave).
interface sram_ext_controller_if;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
    logic [31:0] sram_rdata;
    logic        sram_wait;
    logic        sram_active;

    modport master (
        output wen, addr, wdata, byte_en,
        input  sram_rdata, sram_wait, sram_active
    );

    modport slave (
        input  wen, addr, wdata, byte_en,
        output sram_rdata, sram_wait, sram_active
    );
endinterface

// File: rtl/sram_ext_controller.sv
// Memory-mux backend for an external asynchronous 16-bit SRAM: each 32-bit request
// is split into up to two timed half-word accesses driven from registered pins.
module sram_ext_controller #(
    parameter logic [31:0] ADDR_BASE   = 32'h2000_0000,
    parameter int          ADDR_WIDTH  = 18,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  nRST,
    sram_ext_controller_if.slave  bus,
    output logic [ADDR_WIDTH-1:0] ext_addr,
    output logic [15:0]           ext_dq_out,
    input  logic [15:0]           ext_dq_in,
    output logic                  ext_dq_oe,
    output logic                  ext_ce_n,
    output logic                  ext_oe_n,
    output logic                  ext_we_n,
    output logic                  ext_ub_n,
    output logic                  ext_lb_n
);
    localparam int IDX_W = ADDR_WIDTH - 1;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LO_SETUP  = 3'd1;
    localparam logic [2:0] ST_LO_STROBE = 3'd2;
    localparam logic [2:0] ST_LO_HOLD   = 3'd3;
    localparam logic [2:0] ST_HI_SETUP  = 3'd4;
    localparam logic [2:0] ST_HI_STROBE = 3'd5;
    localparam logic [2:0] ST_HI_HOLD   = 3'd6;
    localparam logic [2:0] ST_DONE      = 3'd7;

    // A write skips any half whose two lane enables are clear; reads use both.
    function automatic logic need_lo(input logic is_wr, input logic [3:0] be);
        return !is_wr || (be[1:0] != 2'b00);
    endfunction

    function automatic logic need_hi(input logic is_wr, input logic [3:0] be);
        return !is_wr || (be[3:2] != 2'b00);
    endfunction

    logic [2:0]       state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic             wen_r;
    logic [IDX_W-1:0] idx_r;
    logic [31:0]      wdata_r;
    logic [3:0]       be_r;
    logic [15:0]      rd_lo_r;
    logic [31:0]      rdata_r;

    logic             active_s, strobe_last_s;
    logic             wen_eff_s;
    logic [IDX_W-1:0] idx_eff_s;
    logic [31:0]      wdata_eff_s;
    logic [3:0]       be_eff_s;
    logic             lo_nxt_s, hi_nxt_s, acc_nxt_s, stb_nxt_s;
    logic [1:0]       lane_be_s;
    logic [15:0]      half_data_s;
    logic [ADDR_WIDTH-1:0] addr_nxt_s;
    logic [15:0]      dq_out_nxt_s;
    logic             dq_oe_nxt_s, ce_n_nxt_s, oe_n_nxt_s, we_n_nxt_s, ub_n_nxt_s, lb_n_nxt_s;
    logic             unused_addr_lsb_s;

    assign unused_addr_lsb_s = ^bus.addr[1:0];
    assign active_s        = (bus.addr[31:ADDR_WIDTH+1] == ADDR_BASE[31:ADDR_WIDTH+1]);
    assign bus.sram_active = active_s;
    assign bus.sram_wait   = active_s && (state_r != ST_DONE);
    assign bus.sram_rdata  = rdata_r;
    assign strobe_last_s   = (cnt_r == CNT_LAST);

    // In IDLE the pins are set up for the first half straight from the bus inputs.
    assign wen_eff_s   = (state_r == ST_IDLE) ? bus.wen                  : wen_r;
    assign idx_eff_s   = (state_r == ST_IDLE) ? bus.addr[ADDR_WIDTH:2]   : idx_r;
    assign wdata_eff_s = (state_r == ST_IDLE) ? bus.wdata                : wdata_r;
    assign be_eff_s    = (state_r == ST_IDLE) ? bus.byte_en              : be_r;

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!active_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (need_lo(bus.wen, bus.byte_en)) begin
                    state_nxt_s = ST_LO_SETUP;
                end else if (need_hi(bus.wen, bus.byte_en)) begin
                    state_nxt_s = ST_HI_SETUP;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_LO_SETUP:  state_nxt_s = ST_LO_STROBE;
            ST_LO_STROBE: state_nxt_s = strobe_last_s ? ST_LO_HOLD : ST_LO_STROBE;
            ST_LO_HOLD:   state_nxt_s = need_hi(wen_r, be_r) ? ST_HI_SETUP : ST_DONE;
            ST_HI_SETUP:  state_nxt_s = ST_HI_STROBE;
            ST_HI_STROBE: state_nxt_s = strobe_last_s ? ST_HI_HOLD : ST_HI_STROBE;
            ST_HI_HOLD:   state_nxt_s = ST_DONE;
            ST_DONE:      state_nxt_s = ST_IDLE;
            default:      state_nxt_s = ST_IDLE;
        endcase
    end

    // Pin values are derived from the next state so the registered pins line up with it.
    always_comb begin
        lo_nxt_s  = (state_nxt_s == ST_LO_SETUP) || (state_nxt_s == ST_LO_STROBE) || (state_nxt_s == ST_LO_HOLD);
        hi_nxt_s  = (state_nxt_s == ST_HI_SETUP) || (state_nxt_s == ST_HI_STROBE) || (state_nxt_s == ST_HI_HOLD);
        stb_nxt_s = (state_nxt_s == ST_LO_STROBE) || (state_nxt_s == ST_HI_STROBE);
        acc_nxt_s = lo_nxt_s || hi_nxt_s;
        if (lo_nxt_s) begin
            lane_be_s   = be_eff_s[1:0];
            half_data_s = wdata_eff_s[15:0];
        end else begin
            lane_be_s   = be_eff_s[3:2];
            half_data_s = wdata_eff_s[31:16];
        end
        if (acc_nxt_s) begin
            addr_nxt_s = {idx_eff_s, hi_nxt_s};
        end else begin
            addr_nxt_s = ext_addr;
        end
        ce_n_nxt_s   = !acc_nxt_s;
        dq_oe_nxt_s  = acc_nxt_s && wen_eff_s;
        dq_out_nxt_s = dq_oe_nxt_s ? half_data_s : 16'h0000;
        we_n_nxt_s   = !(stb_nxt_s && wen_eff_s);
        oe_n_nxt_s   = !(stb_nxt_s && !wen_eff_s);
        if (acc_nxt_s && wen_eff_s) begin
            ub_n_nxt_s = !lane_be_s[1];
            lb_n_nxt_s = !lane_be_s[0];
        end else if (acc_nxt_s) begin
            ub_n_nxt_s = 1'b0;
            lb_n_nxt_s = 1'b0;
        end else begin
            ub_n_nxt_s = 1'b1;
            lb_n_nxt_s = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Strobe-length counter, cleared outside the strobe states.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (((state_r == ST_LO_STROBE) || (state_r == ST_HI_STROBE)) && !strobe_last_s) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Request capture; fields are frozen for the rest of the access.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wen_r   <= 1'b0;
            idx_r   <= {IDX_W{1'b0}};
            wdata_r <= 32'h0000_0000;
            be_r    <= 4'h0;
        end else if ((state_r == ST_IDLE) && active_s) begin
            wen_r   <= bus.wen;
            idx_r   <= bus.addr[ADDR_WIDTH:2];
            wdata_r <= bus.wdata;
            be_r    <= bus.byte_en;
        end
    end

    // Low half is staged so sram_rdata changes only once the whole word is in.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_lo_r <= 16'h0000;
            rdata_r <= 32'h0000_0000;
        end else if (!wen_r && strobe_last_s) begin
            if (state_r == ST_LO_STROBE) begin
                rd_lo_r <= ext_dq_in;
            end else if (state_r == ST_HI_STROBE) begin
                rdata_r <= {ext_dq_in, rd_lo_r};
            end
        end
    end

    // Registered SRAM pins; reset parks every strobe inactive at once.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ext_addr   <= {ADDR_WIDTH{1'b0}};
            ext_dq_out <= 16'h0000;
            ext_dq_oe  <= 1'b0;
            ext_ce_n   <= 1'b1;
            ext_oe_n   <= 1'b1;
            ext_we_n   <= 1'b1;
            ext_ub_n   <= 1'b1;
            ext_lb_n   <= 1'b1;
        end else begin
            ext_addr   <= addr_nxt_s;
            ext_dq_out <= dq_out_nxt_s;
            ext_dq_oe  <= dq_oe_nxt_s;
            ext_ce_n   <= ce_n_nxt_s;
            ext_oe_n   <= oe_n_nxt_s;
            ext_we_n   <= we_n_nxt_s;
            ext_ub_n   <= ub_n_nxt_s;
            ext_lb_n   <= lb_n_nxt_s;
        end
    end
endmodule

// File: doc/sram_ext_controller.md
# sram_ext_controller

Backend for the on-chip SRAM slot of the memory block interface: decodes its address window, accepts 32-bit read/write requests from the SoC memory mux, and executes each as up to two timed half-word accesses on an external asynchronous 16-bit SRAM. It drives `sram_rdata`, `sram_wait` and `sram_active` back to the mux. Address, data and control strobes on the pins are fully registered.

## Interface
- `ADDR_BASE`, 32'h2000_0000: window base; must be aligned to the window size.
- `ADDR_WIDTH`, 18: external half-word address bits. Window = 2^(ADDR_WIDTH+1) bytes.
- `WAIT_CYCLES`, 2: strobe length per half access, ≥1.
- `CLK`  in  1  system clock.
- `nRST`  in  1  reset; asynchronous, active-low.
- `wen`  in  1  1 = write, 0 = read.
- `addr`  in  32  byte address; bits [1:0] are ignored.
- `wdata`  in  32  write data.
- `byte_en`  in  4  byte lanes; bit n selects byte n.
- `sram_rdata`  out  32  read data.
- `sram_wait`  out  1  request not yet complete.
- `sram_active`  out  1  `addr` is in the window.
- `ext_addr`  out  ADDR_WIDTH  half-word address on the pins.
- `ext_dq_out`  out  16  write data on the pins.
- `ext_dq_in`  in  16  read data from the pins.
- `ext_dq_oe`  out  1  pin output-driver enable.
- `ext_ce_n`, `ext_oe_n`, `ext_we_n`, `ext_ub_n`, `ext_lb_n`  out  1 each  active-low SRAM controls.

## Operation
- `sram_active` = (`addr[31:ADDR_WIDTH+1]` == `ADDR_BASE[31:ADDR_WIDTH+1]`). It is combinational.
- `sram_wait` = `sram_active` && state≠DONE. It is combinational.
- FSM states: IDLE, LO_SETUP, LO_STROBE, LO_HOLD, HI_SETUP, HI_STROBE, HI_HOLD, DONE.
- IDLE with `sram_active`=1:
  - Latch `wen`, word index `addr[ADDR_WIDTH:2]`, `wdata` and `byte_en`.
  - Next state: LO_SETUP if the low half is needed, else HI_SETUP if the high half is needed, else DONE.
- Which halves are needed:
  - Reads always access both halves.
  - A write skips a half whose two `byte_en` bits are both 0.
  - A write with `byte_en`=0 goes to DONE with no pin activity.
- Half-word addressing: the low half uses `ext_addr` = {index,0}; the high half uses {index,1}.
- In SETUP, STROBE and HOLD of either half:
  - `ext_ce_n`=0.
  - `ext_addr` is valid.
  - `ext_lb_n`/`ext_ub_n` = inverse of `byte_en[0]`/`[1]` for the low half and `byte_en[2]`/`[3]` for the high half. Reads drive both to 0.
  - For writes, `ext_dq_oe`=1 and `ext_dq_out` = the selected half of `wdata`.
- STROBE lasts exactly WAIT_CYCLES cycles, counted by an internal counter.
  - `ext_we_n`=0 for writes; `ext_oe_n`=0 for reads.
  - SETUP and HOLD keep both strobes high, giving one cycle of address/data setup and hold.
- Reads register `ext_dq_in` on the clock edge that ends the last STROBE cycle, into the low or high half of `sram_rdata`.
- Transitions:
  - LO_HOLD → HI_SETUP if the high half is needed, else DONE.
  - HI_HOLD → DONE.
  - DONE → IDLE unconditionally. A still-active request restarts from IDLE on the following cycle.
- Request fields are latched only in IDLE. Changing or dropping `addr`/`wen`/`wdata`/`byte_en` mid-access does not alter or abort the access. It completes on the pins; a dropped request sees `sram_wait`=0.
- `sram_rdata` holds its value until the next read completes. Writes never change it.

## Timing
- Reset values:
  - `ext_ce_n`, `ext_oe_n`, `ext_we_n`, `ext_ub_n`, `ext_lb_n` = 1.
  - `ext_dq_oe`=0, `ext_addr`=0, `ext_dq_out`=0.
  - `sram_rdata`=0, state=IDLE, counter=0.
- Asserting `nRST` mid-access forces all strobes high and `ext_dq_oe`=0 immediately (asynchronous). No partial data is written to `sram_rdata`.
- Per-half pin cost: WAIT_CYCLES+2 cycles.
- `sram_wait` is high in the request cycle (IDLE) and in every cycle until DONE. It is low in DONE.
- Cycles with `sram_wait` high, counting the IDLE cycle:
  - Full read or write: 2·(WAIT_CYCLES+2)+1 (9 at default).
  - Single-half write: WAIT_CYCLES+3 (5 at default).
  - `byte_en`=0 write: 1.
- `sram_rdata` is valid in the DONE cycle. The requester samples it when `sram_wait`=0.
- Back-to-back requests: one IDLE cycle separates DONE from the next LO_SETUP.

## Test plan
- Reset: hold `nRST`=0 with random inputs → all `ext_*_n`=1, `ext_dq_oe`=0, `sram_rdata`=0. Assert `nRST` mid-STROBE → strobes high the same cycle.
- Full write then read, default params:
  - Write `addr`=0x2000_0010, `wdata`=0xDEAD_BEEF, `byte_en`=4'hF.
  - Required: `ext_addr`=0x8 then 0x9, with 0xBEEF then 0xDEAD; `ext_we_n` low 2 cycles per half; `sram_wait` high 9 cycles.
  - Read the same address → `sram_rdata`=0xDEAD_BEEF in DONE.
- Byte-lane write: `byte_en`=4'b0100 → only the high half is accessed, `ext_ub_n`=1, `ext_lb_n`=0, `sram_wait` high 5 cycles. `byte_en`=0 → no pin activity, `sram_wait` high 1 cycle.
- Window decode:
  - `addr`=0x1FFF_FFFC or 0x2008_0000 → `sram_active`=0, `sram_wait`=0, FSM stays in IDLE.
  - `addr`=0x2007_FFFC → active, `ext_addr`=0x3FFFE/0x3FFFF.
- Mid-access change: switch `addr` out of the window during LO_STROBE of a read → access completes on the pins, `sram_wait`=0 immediately, `sram_rdata` updates at DONE.
- `WAIT_CYCLES`=1 and =4 builds: STROBE is 1 and 4 cycles; `sram_wait` is high 7 and 13 cycles for a full read.
